// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state encoding and sizing helper for the memory read arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Width of a port index; a single port still needs one bit.
  function automatic int port_w(input int nports);
    return (nports > 1) ? $clog2(nports) : 1;
  endfunction

endpackage

// File: rtl/mem_read_arbiter_rr_picker.sv
// Combinational round-robin selection: first full port at or after the pointer, wrapping.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int PW     = port_w(NPORTS)
) (
  input  logic [NPORTS-1:0] full,
  input  logic [PW-1:0]     ptr,
  output logic [PW-1:0]     winner,
  output logic              any_full
);

  int idx;

  // Scanning from the farthest candidate back to the pointer leaves the nearest full port last.
  always_comb begin
    winner   = ptr;
    any_full = |full;
    idx      = 0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NPORTS;
      if (full[idx]) begin
        winner = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Arbitrates NPORTS buffered read requesters onto the single mem read port, round-robin,
// with one readEnable pulse per grant and a watchdog that aborts unanswered reads.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NPORTS  = 2,
  parameter int TIMEOUT = 200
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        req_valid,
  input  logic [ADDR_W*NPORTS-1:0] req_addr,
  output logic [NPORTS-1:0]        req_ready,
  output logic [NPORTS-1:0]        resp_valid,
  output logic                     resp_err,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     mem_re,
  output logic [ADDR_W-1:0]        mem_raddr,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int          PW          = port_w(NPORTS);
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  arb_state_t        state;
  logic [NPORTS-1:0] full;
  logic [ADDR_W-1:0] buf_addr [NPORTS];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     winner;
  logic [PW-1:0]     pick;
  logic              any_full;
  logic [15:0]       wdog;
  logic              hit;
  logic              expire;
  logic              done;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    if (int'(p) >= NPORTS - 1) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  rr_picker #(
    .NPORTS (NPORTS),
    .PW     (PW)
  ) u_picker (
    .full     (full),
    .ptr      (ptr),
    .winner   (pick),
    .any_full (any_full)
  );

  assign req_ready = ~full;

  // A memory answer wins over a watchdog expiry landing on the same edge.
  assign hit    = (state == WAIT) && mem_ready;
  assign expire = (state == WAIT) && !mem_ready && ((wdog + 16'd1) == TIMEOUT_CNT);
  assign done   = hit || expire;

  // Request buffers: fill on accept, empty on the edge that raises the port's response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        buf_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (done && (winner == PW'(i))) begin
          full[i] <= 1'b0;
        end else if (req_valid[i] && !full[i]) begin
          full[i]     <= 1'b1;
          buf_addr[i] <= req_addr[ADDR_W*i +: ADDR_W];
        end
      end
    end
  end

  // Grant FSM; mem_re is registered so it is high only for the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      winner     <= '0;
      ptr        <= '0;
      wdog       <= '0;
      mem_re     <= 1'b0;
      mem_raddr  <= '0;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else begin
      mem_re     <= 1'b0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_full) begin
            winner    <= pick;
            mem_re    <= 1'b1;
            mem_raddr <= buf_addr[pick];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wdog <= wdog + 16'd1;
          if (done) begin
            resp_valid[winner] <= 1'b1;
            resp_err           <= expire;
            resp_data          <= hit ? mem_rdata : '0;
            ptr                <= next_port(winner);
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: a 100-count memory model on the main instance and a
// never-answering memory on a short-timeout instance.
module tb_mem_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [31:0] req_addr;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic        resp_err;
  logic [15:0] resp_data;
  logic        mem_re;
  logic [15:0] mem_raddr;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;

  logic [1:0]  t_req_valid;
  logic [31:0] t_req_addr;
  logic [1:0]  t_req_ready;
  logic [1:0]  t_resp_valid;
  logic        t_resp_err;
  logic [15:0] t_resp_data;
  logic        t_mem_re;
  logic [15:0] t_mem_raddr;
  logic        t_mem_ready;
  logic [15:0] t_mem_rdata = 16'hBEEF;

  int checks   = 0;
  int failures = 0;

  int          n;
  int          re_n;
  int          re_at;
  logic [15:0] re_addr;
  logic [1:0]  rdy_or;

  always #5 clk = ~clk;

  mem_read_arbiter #(.NPORTS(2), .TIMEOUT(200)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_data  (resp_data),
    .mem_re     (mem_re),
    .mem_raddr  (mem_raddr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  mem_read_arbiter #(.NPORTS(2), .TIMEOUT(20)) u_dut_to (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (t_req_valid),
    .req_addr   (t_req_addr),
    .req_ready  (t_req_ready),
    .resp_valid (t_resp_valid),
    .resp_err   (t_resp_err),
    .resp_data  (t_resp_data),
    .mem_re     (t_mem_re),
    .mem_raddr  (t_mem_raddr),
    .mem_ready  (t_mem_ready),
    .mem_rdata  (t_mem_rdata)
  );

  // Memory contents: 0x0005 holds 0x1234, every other word holds addr ^ 0xA5A5.
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return (a == 16'h0005) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction

  // 100-count memory: samples readEnable at E2, raises ready for the cycle after E101.
  logic [15:0] m_addr = 16'h0000;
  int          m_cnt  = 0;
  logic        m_busy = 1'b0;
  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (mem_re) begin
      m_busy <= 1'b1;
      m_cnt  <= 1;
      m_addr <= mem_raddr;
    end else if (m_busy) begin
      if (m_cnt == 99) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem_val(m_addr);
        m_busy    <= 1'b0;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  // Steps negedges until a response appears (bounded), recording mem_re activity and req_ready.
  task automatic wait_resp(input int max, output int cnt, output int re_cnt, output int re_first,
                           output logic [15:0] re_a, output logic [1:0] rdy);
    cnt = 0; re_cnt = 0; re_first = -1; re_a = 16'h0000; rdy = 2'b00;
    do begin
      @(negedge clk);
      cnt++;
      if (mem_re) begin
        re_cnt++;
        if (re_first < 0) begin
          re_first = cnt;
          re_a     = mem_raddr;
        end
      end
      if (resp_valid == 2'b00) rdy |= req_ready;
    end while (resp_valid == 2'b00 && cnt < max);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 2'b00; req_addr = '0;
    t_req_valid = 2'b00; t_req_addr = '0; t_mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 2'b11) begin failures++; $display("FAIL reset_req_ready got %b want 11", req_ready); end
    checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got %b want 00", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
    checks++; if (resp_data !== 16'h0000) begin failures++; $display("FAIL reset_resp_data got %h want 0000", resp_data); end
    checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL reset_mem_re got %b want 0", mem_re); end
    checks++; if (mem_raddr !== 16'h0000) begin failures++; $display("FAIL reset_mem_raddr got %h want 0000", mem_raddr); end
    checks++; if (t_req_ready !== 2'b11) begin failures++; $display("FAIL reset_t_req_ready got %b want 11", t_req_ready); end
    checks++; if (t_mem_re !== 1'b0) begin failures++; $display("FAIL reset_t_mem_re got %b want 0", t_mem_re); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL idle_mem_re got %b want 0", mem_re); end
  endtask

  task automatic test_single_read;
    req_valid = 2'b01; req_addr = 32'h0000_0005;
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL single_accept req_ready got %b want 10", req_ready); end
    wait_resp(300, n, re_n, re_at, re_addr, rdy_or);
    checks++; if (n !== 102) begin failures++; $display("FAIL single_latency got %0d want 102", n); end
    checks++; if (resp_valid !== 2'b01) begin failures++; $display("FAIL single_resp_valid got %b want 01", resp_valid); end
    checks++; if (resp_data !== 16'h1234) begin failures++; $display("FAIL single_resp_data got %h want 1234", resp_data); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL single_resp_err got %b want 0", resp_err); end
    checks++; if (re_n !== 1) begin failures++; $display("FAIL single_re_pulses got %0d want 1", re_n); end
    checks++; if (re_at !== 1) begin failures++; $display("FAIL single_re_cycle got %0d want 1", re_at); end
    checks++; if (re_addr !== 16'h0005) begin failures++; $display("FAIL single_raddr got %h want 0005", re_addr); end
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL single_pulse_len got %b want 00", resp_valid); end
    checks++; if (req_ready !== 2'b11) begin failures++; $display("FAIL single_ready_after got %b want 11", req_ready); end
  endtask

  task automatic test_contention(input logic [1:0] first);
    logic [1:0]  second;
    logic [15:0] a_first, a_second, d_first, d_second;
    second   = ~first;
    a_first  = (first == 2'b01) ? 16'h0010 : 16'h0020;
    a_second = (first == 2'b01) ? 16'h0020 : 16'h0010;
    d_first  = (first == 2'b01) ? 16'hA5B5 : 16'hA585;
    d_second = (first == 2'b01) ? 16'hA585 : 16'hA5B5;
    req_valid = 2'b11; req_addr = 32'h0020_0010;
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL cont_accept req_ready got %b want 00", req_ready); end
    wait_resp(300, n, re_n, re_at, re_addr, rdy_or);
    checks++; if (resp_valid !== first) begin failures++; $display("FAIL cont_first_port got %b want %b", resp_valid, first); end
    checks++; if (n !== 102) begin failures++; $display("FAIL cont_first_latency got %0d want 102", n); end
    checks++; if (re_addr !== a_first) begin failures++; $display("FAIL cont_first_raddr got %h want %h", re_addr, a_first); end
    checks++; if (resp_data !== d_first) begin failures++; $display("FAIL cont_first_data got %h want %h", resp_data, d_first); end
    checks++; if (re_n !== 1) begin failures++; $display("FAIL cont_first_re_pulses got %0d want 1", re_n); end
    wait_resp(300, n, re_n, re_at, re_addr, rdy_or);
    checks++; if (resp_valid !== second) begin failures++; $display("FAIL cont_second_port got %b want %b", resp_valid, second); end
    checks++; if (n !== 102) begin failures++; $display("FAIL cont_second_latency got %0d want 102", n); end
    checks++; if (re_at !== 1) begin failures++; $display("FAIL cont_second_issue_cycle got %0d want 1", re_at); end
    checks++; if (re_n !== 1) begin failures++; $display("FAIL cont_second_re_pulses got %0d want 1", re_n); end
    checks++; if (re_addr !== a_second) begin failures++; $display("FAIL cont_second_raddr got %h want %h", re_addr, a_second); end
    checks++; if (resp_data !== d_second) begin failures++; $display("FAIL cont_second_data got %h want %h", resp_data, d_second); end
    @(negedge clk);
    checks++; if (req_ready !== 2'b11) begin failures++; $display("FAIL cont_ready_after got %b want 11", req_ready); end
  endtask

  task automatic test_queued;
    req_valid = 2'b01; req_addr = 32'h0000_0030;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (30) @(negedge clk);
    req_valid = 2'b10; req_addr = 32'h0040_0000;
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL queued_accept req_ready got %b want 00", req_ready); end
    wait_resp(300, n, re_n, re_at, re_addr, rdy_or);
    checks++; if (resp_valid !== 2'b01) begin failures++; $display("FAIL queued_first_port got %b want 01", resp_valid); end
    checks++; if (resp_data !== 16'hA595) begin failures++; $display("FAIL queued_first_data got %h want a595", resp_data); end
    checks++; if (re_n !== 0) begin failures++; $display("FAIL queued_re_during_wait got %0d want 0", re_n); end
    checks++; if (rdy_or[1] !== 1'b0) begin failures++; $display("FAIL queued_ready1_low got %b want 0", rdy_or[1]); end
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL queued_ready_at_resp got %b want 01", req_ready); end
    wait_resp(300, n, re_n, re_at, re_addr, rdy_or);
    checks++; if (resp_valid !== 2'b10) begin failures++; $display("FAIL queued_second_port got %b want 10", resp_valid); end
    checks++; if (resp_data !== 16'hA5E5) begin failures++; $display("FAIL queued_second_data got %h want a5e5", resp_data); end
    checks++; if (n !== 102) begin failures++; $display("FAIL queued_second_latency got %0d want 102", n); end
    checks++; if (re_at !== 1) begin failures++; $display("FAIL queued_second_issue_cycle got %0d want 1", re_at); end
    checks++; if (re_addr !== 16'h0040) begin failures++; $display("FAIL queued_second_raddr got %h want 0040", re_addr); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    logic seen;
    t_req_valid = 2'b01; t_req_addr = 32'h0000_0007;
    @(negedge clk);
    t_req_valid = 2'b00;
    n = 0; re_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (t_mem_re) re_n++;
    end while (t_resp_valid == 2'b00 && n < 100);
    checks++; if (n !== 22) begin failures++; $display("FAIL timeout_latency got %0d want 22", n); end
    checks++; if (t_resp_valid !== 2'b01) begin failures++; $display("FAIL timeout_port got %b want 01", t_resp_valid); end
    checks++; if (t_resp_err !== 1'b1) begin failures++; $display("FAIL timeout_err got %b want 1", t_resp_err); end
    checks++; if (t_resp_data !== 16'h0000) begin failures++; $display("FAIL timeout_data got %h want 0000", t_resp_data); end
    checks++; if (re_n !== 1) begin failures++; $display("FAIL timeout_re_pulses got %0d want 1", re_n); end
    @(negedge clk);
    checks++; if (t_resp_valid !== 2'b00) begin failures++; $display("FAIL timeout_pulse_len got %b want 00", t_resp_valid); end
    checks++; if (t_req_ready !== 2'b11) begin failures++; $display("FAIL timeout_ready_after got %b want 11", t_req_ready); end
    repeat (3) @(negedge clk);
    t_mem_ready = 1'b1;
    @(negedge clk);
    t_mem_ready = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (t_resp_valid != 2'b00 || t_mem_re) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL timeout_stray_ready got %b want 0", seen); end
  endtask

  task automatic test_reset_mid_wait;
    logic seen;
    req_valid = 2'b10; req_addr = 32'h0050_0000;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b11) begin failures++; $display("FAIL rstmid_req_ready got %b want 11", req_ready); end
    checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL rstmid_resp_valid got %b want 00", resp_valid); end
    checks++; if (resp_data !== 16'h0000) begin failures++; $display("FAIL rstmid_resp_data got %h want 0000", resp_data); end
    checks++; if (mem_raddr !== 16'h0000) begin failures++; $display("FAIL rstmid_mem_raddr got %h want 0000", mem_raddr); end
    checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL rstmid_mem_re got %b want 0", mem_re); end
    checks++; if (t_resp_err !== 1'b0) begin failures++; $display("FAIL rstmid_t_resp_err got %b want 0", t_resp_err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (resp_valid != 2'b00 || mem_re) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_late_ready got %b want 0", seen); end
    req_valid = 2'b01; req_addr = 32'h0000_0005;
    @(negedge clk);
    req_valid = 2'b00;
    wait_resp(300, n, re_n, re_at, re_addr, rdy_or);
    checks++; if (n !== 102) begin failures++; $display("FAIL rstmid_fresh_latency got %0d want 102", n); end
    checks++; if (resp_valid !== 2'b01) begin failures++; $display("FAIL rstmid_fresh_port got %b want 01", resp_valid); end
    checks++; if (resp_data !== 16'h1234) begin failures++; $display("FAIL rstmid_fresh_data got %h want 1234", resp_data); end
    checks++; if (re_addr !== 16'h0005) begin failures++; $display("FAIL rstmid_fresh_raddr got %h want 0005", re_addr); end
  endtask

  initial begin
    test_reset;
    test_contention(2'b01);
    test_single_read;
    test_contention(2'b10);
    test_queued;
    test_timeout;
    test_reset_mid_wait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
